upio_in_cond: RTL and testbench

//  Input conditioning stage between the upio pads and the user plugin's upio_in_i.
//  - Per bit: synchronise asynchronous pad levels into clk_i, debounce them, flag edges.
//  - upio_in_o drives the plugin's upio_in_i directly.
//  - Optional edge-interrupt logic gives an int_o to OR with the plugin interrupt.

---
 rtl/upio_in_cond_pkg.sv | 12 +
 rtl/upio_in_cond_if.sv | 27 ++
 rtl/upio_in_cond_bit_deb.sv | 96 +++++++++
 rtl/upio_in_cond.sv | 66 ++++++
 tb/tb_upio_in_cond.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/upio_in_cond_pkg.sv
// Shared types and default parameters for the upio input conditioning stage.
package upio_in_cond_pkg;

  typedef enum logic {
    STABLE,
    COUNTING
  } deb_state_e;

  localparam int unsigned DefaultSyncStages = 2;
  localparam int unsigned DefaultDebCycles  = 8;

endpackage

// File: rtl/upio_in_cond_if.sv
// Pad-side and plugin-side signal bundle of the upio input conditioning stage.
interface upio_in_cond_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] pad_in_i;
  logic [WIDTH-1:0] deb_en_i;
  logic [WIDTH-1:0] irq_rise_i;
  logic [WIDTH-1:0] irq_fall_i;
  logic [WIDTH-1:0] pend_clr_i;
  logic [WIDTH-1:0] upio_in_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic [WIDTH-1:0] pend_o;
  logic             int_o;

  modport slave (
    input  pad_in_i, deb_en_i, irq_rise_i, irq_fall_i, pend_clr_i,
    output upio_in_o, rise_o, fall_o, pend_o, int_o
  );

  modport master (
    output pad_in_i, deb_en_i, irq_rise_i, irq_fall_i, pend_clr_i,
    input  upio_in_o, rise_o, fall_o, pend_o, int_o
  );

endinterface

// File: rtl/upio_in_cond_bit_deb.sv
// One upio bit: pad synchroniser, debounce FSM with stability counter, edge pulse flops.
module upio_bit_deb
  import upio_in_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefaultSyncStages,
  parameter int unsigned DEB_CNT_W   = 4,
  parameter int unsigned DEB_CYCLES  = DefaultDebCycles
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic pad_i,
  input  logic deb_en_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [DEB_CNT_W-1:0] DebLast = DEB_CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_e             state_q;
  logic [DEB_CNT_W-1:0]   cnt_q;
  logic                   out_q, rise_q, fall_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Edge flops follow out_q on the same edge so the pulse coincides with the new level.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (!deb_en_i) begin
        state_q <= STABLE;
        cnt_q   <= '0;
        if (s != out_q) begin
          out_q  <= s;
          rise_q <= s;
          fall_q <= ~s;
        end
      end else begin
        unique case (state_q)
          STABLE: begin
            if (s != out_q) begin
              if (DEB_CYCLES == 1) begin
                out_q  <= s;
                rise_q <= s;
                fall_q <= ~s;
              end else begin
                state_q <= COUNTING;
                cnt_q   <= DEB_CNT_W'(1);
              end
            end
          end
          COUNTING: begin
            if (s == out_q) begin
              state_q <= STABLE;
              cnt_q   <= '0;
            end else if (cnt_q == DebLast) begin
              out_q   <= s;
              rise_q  <= s;
              fall_q  <= ~s;
              state_q <= STABLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/upio_in_cond.sv
// upio pad input conditioning: per-bit sync/debounce/edge detect plus optional edge interrupts.
// Edge interrupt logic is built only when UPIO_IN_COND_IRQ_EN is defined.
module upio_in_cond
  import upio_in_cond_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages,
  parameter int unsigned DEB_CNT_W   = 4,
  parameter int unsigned DEB_CYCLES  = DefaultDebCycles
) (
  input logic           clk_i,
  input logic           rst_n,
  upio_in_cond_if.slave bus
);

  logic [WIDTH-1:0] out_w, rise_w, fall_w;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    upio_bit_deb #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CNT_W   (DEB_CNT_W),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_bit (
      .clk_i    (clk_i),
      .rst_n    (rst_n),
      .pad_i    (bus.pad_in_i[gi]),
      .deb_en_i (bus.deb_en_i[gi]),
      .out_o    (out_w[gi]),
      .rise_o   (rise_w[gi]),
      .fall_o   (fall_w[gi])
    );
  end

  assign bus.upio_in_o = out_w;
  assign bus.rise_o    = rise_w;
  assign bus.fall_o    = fall_w;

`ifdef UPIO_IN_COND_IRQ_EN
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             int_q;

  // Set terms are ORed after the clear so a coincident edge keeps the bit pending.
  always_comb begin
    pend_d = (pend_q & ~bus.pend_clr_i) | (rise_w & bus.irq_rise_i) | (fall_w & bus.irq_fall_i);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      int_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      int_q  <= |pend_q;
    end
  end

  assign bus.pend_o = pend_q;
  assign bus.int_o  = int_q;
`else
  logic unused_irq;
  assign unused_irq = ^{bus.irq_rise_i, bus.irq_fall_i, bus.pend_clr_i};
  assign bus.pend_o = '0;
  assign bus.int_o  = 1'b0;
`endif

endmodule

// File: tb/tb_upio_in_cond.sv
// Randomized and directed checks of upio_in_cond against a window-based behavioural model.
module tb_upio_in_cond;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DC = 8;
  localparam logic [15:0] Mask = 16'((1 << DC) - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  upio_in_cond_if #(.WIDTH(W)) bus ();

  upio_in_cond #(
    .WIDTH       (W),
    .SYNC_STAGES (SS),
    .DEB_CNT_W   (4),
    .DEB_CYCLES  (DC)
  ) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: level = s after SS cycles; debounced level flips once the last DC samples all differ.
  logic [W-1:0] m_out, m_rise, m_fall, m_pend;
  logic         m_int;
  logic [W-1:0] padq[$];
  logic [15:0]  win [W];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_out = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_int = 1'b0;
    padq.delete();
    for (int k = 0; k < SS; k++) padq.push_back('0);
    for (int i = 0; i < W; i++) win[i] = '0;
  endfunction

  function automatic void model_edge();
    logic [W-1:0] s, nout;
    s = padq.pop_front();
    padq.push_back(bus.pad_in_i);
    for (int i = 0; i < W; i++) begin
      win[i] = {win[i][14:0], s[i]};
      if (!bus.deb_en_i[i]) nout[i] = s[i];
      else if ((win[i] & Mask) == (m_out[i] ? 16'h0 : Mask)) nout[i] = ~m_out[i];
      else nout[i] = m_out[i];
    end
`ifdef UPIO_IN_COND_IRQ_EN
    m_int  = |m_pend;
    m_pend = (m_pend & ~bus.pend_clr_i) | (m_rise & bus.irq_rise_i) | (m_fall & bus.irq_fall_i);
`endif
    m_rise = nout & ~m_out;
    m_fall = ~nout & m_out;
    m_out  = nout;
  endfunction

  task automatic compare();
    chk("upio_in_o", 32'(bus.upio_in_o), 32'(m_out));
    chk("rise_o", 32'(bus.rise_o), 32'(m_rise));
    chk("fall_o", 32'(bus.fall_o), 32'(m_fall));
    chk("pend_o", 32'(bus.pend_o), 32'(m_pend));
    chk("int_o", 32'(bus.int_o), 32'(m_int));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1 compare();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int cnt_r;

  initial begin
    bus.pad_in_i = '0; bus.deb_en_i = '1; bus.irq_rise_i = '0;
    bus.irq_fall_i = '0; bus.pend_clr_i = '0;
    model_reset();
    #1 compare();
    steps(3);
    rst_n = 1'b1;
    steps(3);

    // Reset mid-count discards the count; debounce restarts from the sync chain.
    bus.pad_in_i[0] = 1'b1;
    steps(3);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    chk("rst_upio", 32'(bus.upio_in_o), 32'h0);
    chk("rst_int", 32'(bus.int_o), 32'h0);
    steps(2);
    rst_n = 1'b1;
    steps(9);
    chk("rst_restart_9", 32'(bus.upio_in_o[0]), 32'h0);
    step();
    chk("rst_restart_10", 32'(bus.upio_in_o[0]), 32'h1);
    chk("rst_restart_rise", 32'(bus.rise_o[0]), 32'h1);
    bus.pad_in_i[0] = 1'b0;
    steps(14);

    // Bypass: three cycles from pad to output.
    bus.deb_en_i = '0;
    steps(2);
    bus.pad_in_i[2] = 1'b1;
    steps(2);
    chk("byp_early", 32'(bus.upio_in_o[2]), 32'h0);
    step();
    chk("byp_level", 32'(bus.upio_in_o[2]), 32'h1);
    chk("byp_rise", 32'(bus.rise_o[2]), 32'h1);
    step();
    chk("byp_rise_gone", 32'(bus.rise_o[2]), 32'h0);
    bus.pad_in_i[2] = 1'b0;
    steps(4);
    bus.deb_en_i = '1;
    steps(2);

    // Debounce: held level appears at cycle 10, a 7-cycle pulse is swallowed.
    bus.pad_in_i[1] = 1'b1;
    steps(9);
    chk("deb_early", 32'(bus.upio_in_o[1]), 32'h0);
    step();
    chk("deb_level", 32'(bus.upio_in_o[1]), 32'h1);
    chk("deb_rise", 32'(bus.rise_o[1]), 32'h1);
    bus.pad_in_i[1] = 1'b0;
    steps(14);
    bus.pad_in_i[1] = 1'b1;
    steps(7);
    bus.pad_in_i[1] = 1'b0;
    cnt_r = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      cnt_r += int'(bus.rise_o[1]);
    end
    chk("deb_short_rise", 32'(cnt_r), 32'h0);
    chk("deb_short_level", 32'(bus.upio_in_o[1]), 32'h0);

    // Glitch: count restarts at the final rise.
    cnt_r = 0;
    bus.pad_in_i[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin step(); cnt_r += int'(bus.rise_o[3]); end
    bus.pad_in_i[3] = 1'b0;
    step(); cnt_r += int'(bus.rise_o[3]);
    bus.pad_in_i[3] = 1'b1;
    for (int k = 0; k < 9; k++) begin step(); cnt_r += int'(bus.rise_o[3]); end
    chk("glitch_early", 32'(bus.upio_in_o[3]), 32'h0);
    step(); cnt_r += int'(bus.rise_o[3]);
    chk("glitch_rise", 32'(bus.rise_o[3]), 32'h1);
    for (int k = 0; k < 5; k++) begin step(); cnt_r += int'(bus.rise_o[3]); end
    chk("glitch_single", 32'(cnt_r), 32'h1);
    bus.pad_in_i[3] = 1'b0;
    steps(12);

    // Interrupt path on bit 5 falling edges.
    bus.deb_en_i[5] = 1'b0;
    bus.irq_fall_i[5] = 1'b1;
    bus.pad_in_i[5] = 1'b1;
    steps(6);
    bus.pad_in_i[5] = 1'b0;
    steps(3);
    chk("irq_fall", 32'(bus.fall_o[5]), 32'h1);
    step();
`ifdef UPIO_IN_COND_IRQ_EN
    chk("irq_pend", 32'(bus.pend_o[5]), 32'h1);
    step();
    chk("irq_int", 32'(bus.int_o), 32'h1);
    bus.pad_in_i[5] = 1'b1;
    steps(5);
    bus.pad_in_i[5] = 1'b0;
    steps(3);
    bus.pend_clr_i[5] = 1'b1;
    step();
    chk("irq_set_wins", 32'(bus.pend_o[5]), 32'h1);
    step();
    chk("irq_cleared", 32'(bus.pend_o[5]), 32'h0);
    bus.pend_clr_i[5] = 1'b0;
    step();
    chk("irq_int_low", 32'(bus.int_o), 32'h0);
`else
    cnt_r = 0;
    for (int k = 0; k < 6; k++) begin step(); cnt_r += int'(bus.int_o); end
    chk("irq_off_int", 32'(cnt_r), 32'h0);
`endif
    bus.irq_fall_i = '0;
    bus.deb_en_i = '1;
    steps(4);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 5) == 0) bus.pad_in_i[i] = ~bus.pad_in_i[i];
      if ($urandom_range(0, 63) == 0) bus.deb_en_i = W'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        bus.irq_rise_i = W'($urandom);
        bus.irq_fall_i = W'($urandom);
      end
      bus.pend_clr_i = W'($urandom & $urandom & $urandom);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1 compare();
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
